// File: rtl/phase_array_pkg.sv
// Shared opcodes, status-bit indices, command field layout and step-FSM states
// for the phased shift-register array engine.
package phase_array_pkg;

  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_SWAP   = 4'h2;
  localparam logic [3:0] OP_DUTY   = 4'h3;
  localparam logic [3:0] OP_READ   = 4'h4;
  localparam logic [3:0] OP_STATUS = 4'h5;

  localparam int ST_BAD  = 0;
  localparam int ST_SWAP = 1;
  localparam int ST_DUTY = 2;
  localparam int ST_OVF  = 3;

  localparam int CMD_W  = 24;
  localparam int OP_LSB = 20;
  localparam int CH_LSB = 8;
  localparam int CH_FW  = 12;
  localparam int EN_BIT = 7;
  localparam int PH_W   = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LATCH
  } step_state_e;

endpackage

// File: rtl/phase_bank.sv
// Double-buffered per-channel {enable, phase} tables: commands write the shadow
// bank, and a one-cycle copy moves the whole shadow bank into the active bank.
module phase_bank
  import phase_array_pkg::*;
#(
  parameter int N_CH = 128,
  parameter int CH_W = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_i,
  input  logic [CH_W-1:0]      ch_i,
  input  logic                 wr_en_i,
  input  logic [PH_W-1:0]      wr_ph_i,
  output logic                 rd_en_o,
  output logic [PH_W-1:0]      rd_ph_o,
  input  logic                 copy_i,
  output logic [N_CH-1:0]      sh_en_o,
  output logic [N_CH*PH_W-1:0] sh_ph_o,
  output logic [N_CH-1:0]      act_en_o,
  output logic [N_CH*PH_W-1:0] act_ph_o
);

  logic [N_CH-1:0]      sh_en_q,  act_en_q;
  logic [N_CH*PH_W-1:0] sh_ph_q,  act_ph_q;

  // Copy reads the pre-write shadow, so a write in the copy cycle lands only in shadow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_en_q  <= '0;
      sh_ph_q  <= '0;
      act_en_q <= '0;
      act_ph_q <= '0;
    end else begin
      if (copy_i) begin
        act_en_q <= sh_en_q;
        act_ph_q <= sh_ph_q;
      end
      if (wr_i) begin
        sh_en_q[ch_i]                      <= wr_en_i;
        sh_ph_q[PH_W*int'(ch_i) +: PH_W]   <= wr_ph_i;
      end
    end
  end

  assign rd_en_o  = sh_en_q[ch_i];
  assign rd_ph_o  = sh_ph_q[PH_W*int'(ch_i) +: PH_W];
  assign sh_en_o  = sh_en_q;
  assign sh_ph_o  = sh_ph_q;
  assign act_en_o = act_en_q;
  assign act_ph_o = act_ph_q;

endmodule

// File: rtl/phase_array_engine.sv
// Drives N_LINES serial lines into CHAIN_LEN-deep shift-register chains, producing
// N_LINES*CHAIN_LEN phased square waves; handles the 24-bit command/reply channel.
module phase_array_engine
  import phase_array_pkg::*;
#(
  parameter int N_LINES     = 16,
  parameter int CHAIN_LEN   = 8,
  parameter int PERIOD      = 24,
  parameter int CLK_DIV     = 2,
  parameter int STEP_CYCLES = 50
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_command,
  input  logic [CMD_W-1:0]   i_command_data,
  input  logic               i_overflow,
  output logic [N_LINES-1:0] o_channel,
  output logic               o_data_clk,
  output logic               o_latch,
  output logic               o_sync,
  output logic               o_reply,
  output logic [CMD_W-1:0]   o_reply_data
);

  localparam int N_CH   = N_LINES * CHAIN_LEN;
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SLOT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int CYC_W  = $clog2(STEP_CYCLES + 1);
  localparam logic [7:0] PERIOD8 = 8'(PERIOD);

  if (STEP_CYCLES < (2*CHAIN_LEN + 1)*CLK_DIV) begin : g_step_check
    $error("STEP_CYCLES too small to shift CHAIN_LEN bits and latch");
  end
  if (PERIOD < 2 || PERIOD > 128) begin : g_period_check
    $error("PERIOD must be in 2..128");
  end

  // Output bit per line for one slot: en && ((step - phase) mod PERIOD) < duty.
  function automatic logic [N_LINES-1:0] slot_bits(
    input logic [7:0]           step,
    input logic [SLOT_W-1:0]    slot,
    input logic [N_CH-1:0]      en,
    input logic [N_CH*PH_W-1:0] ph,
    input logic [7:0]           duty
  );
    logic [7:0] p;
    logic [7:0] d;
    int         c;
    slot_bits = '0;
    for (int l = 0; l < N_LINES; l++) begin
      c = int'(slot) * N_LINES + l;
      p = {1'b0, ph[c*PH_W +: PH_W]};
      d = (step >= p) ? step - p : step + PERIOD8 - p;
      slot_bits[l] = en[c] && (d < duty);
    end
  endfunction

  // ---- command capture stage
  logic             cmd_vld_q;
  logic [CMD_W-1:0] cmd_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) cmd_vld_q <= 1'b0;
    else         cmd_vld_q <= i_command;
  end

  always_ff @(posedge i_clk) begin
    cmd_q <= i_command_data;
  end

  logic [3:0]       op;
  logic [CH_FW-1:0] ch;
  logic [PH_W-1:0]  arg;
  logic             ch_ok;

  assign op    = cmd_q[OP_LSB +: 4];
  assign ch    = cmd_q[CH_LSB +: CH_FW];
  assign arg   = cmd_q[PH_W-1:0];
  assign ch_ok = 32'(ch) < 32'(N_CH);

  // ---- bank and step-boundary hand-over
  logic                 bank_wr, rd_en, copy, dapply, boundary0;
  logic [PH_W-1:0]      rd_ph;
  logic [N_CH-1:0]      sh_en, act_en, tbl_en;
  logic [N_CH*PH_W-1:0] sh_ph, act_ph, tbl_ph;

  phase_bank #(.N_CH(N_CH), .CH_W(CH_W)) u_bank (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .wr_i    (bank_wr),
    .ch_i    (ch[CH_W-1:0]),
    .wr_en_i (cmd_q[EN_BIT]),
    .wr_ph_i (arg),
    .rd_en_o (rd_en),
    .rd_ph_o (rd_ph),
    .copy_i  (copy),
    .sh_en_o (sh_en),
    .sh_ph_o (sh_ph),
    .act_en_o(act_en),
    .act_ph_o(act_ph)
  );

  logic       swap_pend_q, duty_pend_q, ovf_q;
  logic       swap_pend_d, duty_pend_d, ovf_d;
  logic [7:0] duty_q, duty_pval_q, duty_d, duty_pval_d, tbl_duty;
  logic       bad, swap_set, duty_set, ovf_clr;
  logic [15:0] payload;
  logic [3:0]  status;

  always_comb begin
    bank_wr  = 1'b0;
    bad      = 1'b0;
    swap_set = 1'b0;
    duty_set = 1'b0;
    ovf_clr  = 1'b0;
    payload  = '0;
    if (cmd_vld_q) begin
      unique case (op)
        OP_WRITE: begin
          payload = {4'b0, ch};
          if (!ch_ok || ({1'b0, arg} >= PERIOD8)) bad = 1'b1;
          else bank_wr = 1'b1;
        end
        OP_SWAP:  swap_set = 1'b1;
        OP_DUTY: begin
          if ({1'b0, arg} > PERIOD8) bad = 1'b1;
          else duty_set = 1'b1;
        end
        OP_READ: begin
          if (!ch_ok) bad = 1'b1;
          else payload = {8'b0, rd_en, rd_ph};
        end
        OP_STATUS: begin
          payload = {8'(CHAIN_LEN), PERIOD8};
          ovf_clr = 1'b1;
        end
        default:  bad = 1'b1;
      endcase
    end
  end

  // Hand-over is cleared first, so a SWAP/DUTY in the copy cycle stays pending for the next period.
  assign copy        = boundary0 && swap_pend_q;
  assign dapply      = boundary0 && duty_pend_q;
  assign swap_pend_d = (swap_pend_q && !copy) || swap_set;
  assign duty_pend_d = (duty_pend_q && !dapply) || duty_set;
  assign duty_pval_d = duty_set ? {1'b0, arg} : duty_pval_q;
  assign duty_d      = dapply ? duty_pval_q : duty_q;
  assign ovf_d       = i_overflow || (ovf_q && !ovf_clr);
  assign tbl_en      = copy ? sh_en : act_en;
  assign tbl_ph      = copy ? sh_ph : act_ph;
  assign tbl_duty    = duty_d;

  always_comb begin
    status          = '0;
    status[ST_OVF]  = ovf_q;
    status[ST_DUTY] = duty_pend_d;
    status[ST_SWAP] = swap_pend_d;
    status[ST_BAD]  = bad;
  end

  logic             reply_q;
  logic [CMD_W-1:0] reply_data_q;

  // ---- reply stage
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      swap_pend_q  <= 1'b0;
      duty_pend_q  <= 1'b0;
      ovf_q        <= 1'b0;
      duty_q       <= 8'(PERIOD / 2);
      duty_pval_q  <= 8'(PERIOD / 2);
      reply_q      <= 1'b0;
      reply_data_q <= '0;
    end else begin
      swap_pend_q  <= swap_pend_d;
      duty_pend_q  <= duty_pend_d;
      ovf_q        <= ovf_d;
      duty_q       <= duty_d;
      duty_pval_q  <= duty_pval_d;
      reply_q      <= cmd_vld_q;
      reply_data_q <= cmd_vld_q ? {op, status, payload} : '0;
    end
  end

  // ---- step FSM and shift/latch outputs
  step_state_e       state_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [DIV_W-1:0]  div_q;
  logic [SLOT_W-1:0] slot_q;
  logic [7:0]        step_q, step_nxt;
  logic              fresh_q, step_end, div_last, slot_last;
  logic [N_LINES-1:0] chan_q;
  logic              dclk_q, latch_q, sync_q;

  assign step_end  = (cyc_q == CYC_W'(STEP_CYCLES - 1));
  assign div_last  = (div_q == DIV_W'(CLK_DIV - 1));
  assign slot_last = (slot_q == SLOT_W'(CHAIN_LEN - 1));
  assign step_nxt  = (fresh_q || step_q == PERIOD8 - 8'd1) ? 8'd0 : step_q + 8'd1;
  assign boundary0 = step_end && (step_nxt == 8'd0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cyc_q   <= CYC_W'(STEP_CYCLES - 1);
      fresh_q <= 1'b1;
      step_q  <= '0;
      slot_q  <= '0;
      div_q   <= '0;
      chan_q  <= '0;
      dclk_q  <= 1'b0;
      latch_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      cyc_q <= step_end ? '0 : cyc_q + 1'b1;
      if (step_end) begin
        state_q <= S_SETUP;
        fresh_q <= 1'b0;
        step_q  <= step_nxt;
        slot_q  <= '0;
        div_q   <= '0;
        chan_q  <= slot_bits(step_nxt, '0, tbl_en, tbl_ph, tbl_duty);
        dclk_q  <= 1'b0;
        latch_q <= 1'b0;
        sync_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_SETUP: begin
            if (div_last) begin
              state_q <= S_HIGH;
              div_q   <= '0;
              dclk_q  <= 1'b1;
            end else div_q <= div_q + 1'b1;
          end
          S_HIGH: begin
            if (div_last) begin
              div_q  <= '0;
              dclk_q <= 1'b0;
              if (slot_last) begin
                state_q <= S_LATCH;
                chan_q  <= '0;
                latch_q <= 1'b1;
                sync_q  <= (step_q == 8'd0);
              end else begin
                state_q <= S_SETUP;
                slot_q  <= slot_q + 1'b1;
                chan_q  <= slot_bits(step_q, slot_q + 1'b1, act_en, act_ph, duty_q);
              end
            end else div_q <= div_q + 1'b1;
          end
          S_LATCH: begin
            if (div_last) begin
              state_q <= S_IDLE;
              div_q   <= '0;
              latch_q <= 1'b0;
              sync_q  <= 1'b0;
            end else div_q <= div_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_channel    = chan_q;
  assign o_data_clk   = dclk_q;
  assign o_latch      = latch_q;
  assign o_sync       = sync_q;
  assign o_reply      = reply_q;
  assign o_reply_data = reply_data_q;

endmodule

// File: tb/tb_phase_array_engine.sv
// Directed bench for phase_array_engine: a 74HC595 chain model rebuilds the
// latched channel vector per step; command replies are checked against constants.
module tb_phase_array_engine;

  localparam int NL  = 2;
  localparam int CL  = 4;
  localparam int PER = 8;
  localparam int CD  = 1;
  localparam int SC  = 12;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_command = 1'b0;
  logic [23:0] i_command_data = '0;
  logic        i_overflow = 1'b0;
  logic [NL-1:0] o_channel;
  logic        o_data_clk, o_latch, o_sync, o_reply;
  logic [23:0] o_reply_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  phase_array_engine #(
    .N_LINES(NL), .CHAIN_LEN(CL), .PERIOD(PER), .CLK_DIV(CD), .STEP_CYCLES(SC)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_command     (i_command),
    .i_command_data(i_command_data),
    .i_overflow    (i_overflow),
    .o_channel     (o_channel),
    .o_data_clk    (o_data_clk),
    .o_latch       (o_latch),
    .o_sync        (o_sync),
    .o_reply       (o_reply),
    .o_reply_data  (o_reply_data)
  );

  // Shift-register chain model: slot 0 enters first and ends at the far end (bit CL-1).
  logic [CL-1:0] sr [NL];
  logic [7:0]    pat [PER];
  logic [7:0]    lat_vec = '0;
  logic          last_sync = 1'b0, prev_dclk = 1'b0, prev_lat = 1'b0;
  int            lat_step = 0, lat_cnt = 0, sync_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (o_data_clk && !prev_dclk)
      for (int l = 0; l < NL; l++) sr[l] = {sr[l][CL-2:0], o_channel[l]};
    if (o_latch && !prev_lat) begin
      for (int c = 0; c < NL*CL; c++) lat_vec[c] = sr[c % NL][CL-1-(c / NL)];
      lat_step = o_sync ? 0 : (lat_step + 1) % PER;
      pat[lat_step] = lat_vec;
      last_sync = o_sync;
      lat_cnt++;
      if (o_sync) sync_cnt++;
    end
    prev_dclk = o_data_clk;
    prev_lat  = o_latch;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_cmd(input logic [23:0] w, output logic [23:0] rep, output logic [2:0] strb);
    i_command = 1'b1;
    i_command_data = w;
    tick();
    i_command = 1'b0;
    i_command_data = '0;
    strb[0] = o_reply;
    tick();
    strb[1] = o_reply;
    rep = o_reply_data;
    tick();
    strb[2] = o_reply;
  endtask

  task automatic wait_sync();
    int s0 = sync_cnt;
    for (int i = 0; i < 300 && sync_cnt == s0; i++) tick();
    n_cmp++;
    if (sync_cnt == s0) begin
      n_err++;
      $display("FAIL wait_sync: no o_sync latch within 300 cycles");
    end
  endtask

  task automatic wait_latches(input int n);
    int l0 = lat_cnt;
    for (int i = 0; i < 40*n && lat_cnt < l0 + n; i++) tick();
    n_cmp++;
    if (lat_cnt < l0 + n) begin
      n_err++;
      $display("FAIL wait_latches: got %0d latches want %0d", lat_cnt - l0, n);
    end
  endtask

  task automatic test_reset();
    logic [23:0] rep;
    logic [2:0]  strb;
    i_reset = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({o_channel, o_data_clk, o_latch, o_sync, o_reply, o_reply_data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ch=%b dclk=%b lat=%b sync=%b rep=%b data=%h want all 0",
               o_channel, o_data_clk, o_latch, o_sync, o_reply, o_reply_data);
    end
    i_reset = 1'b0;
    tick();
    do_cmd(24'h500000, rep, strb);
    n_cmp++;
    if (strb !== 3'b010) begin
      n_err++;
      $display("FAIL status_strobe: got %b want 010", strb);
    end
    n_cmp++;
    if (rep !== 24'h500408) begin
      n_err++;
      $display("FAIL status_reply: got %h want 500408", rep);
    end
  endtask

  task automatic test_write_swap();
    logic [23:0] rep;
    logic [2:0]  strb;
    logic [7:0]  exp;
    wait_sync();
    do_cmd(24'h100583, rep, strb);
    n_cmp++;
    if (rep !== 24'h100005 || strb !== 3'b010) begin
      n_err++;
      $display("FAIL write_reply: got %h/%b want 100005/010", rep, strb);
    end
    do_cmd(24'h200000, rep, strb);
    n_cmp++;
    if (rep !== 24'h220000) begin
      n_err++;
      $display("FAIL swap_reply: got %h want 220000", rep);
    end
    wait_sync();
    wait_latches(PER - 1);
    for (int s = 0; s < PER; s++) begin
      exp = (s >= 3 && s <= 6) ? 8'h20 : 8'h00;
      n_cmp++;
      if (pat[s] !== exp) begin
        n_err++;
        $display("FAIL swap_pattern step %0d: got %h want %h", s, pat[s], exp);
      end
    end
  endtask

  task automatic test_bad_args();
    logic [23:0] rep;
    logic [2:0]  strb;
    logic [23:0] cmds [5] = '{24'h100588, 24'h400500, 24'h400400, 24'h400800, 24'h700000};
    logic [23:0] exps [5] = '{24'h110005, 24'h400083, 24'h400000, 24'h410000, 24'h710000};
    for (int i = 0; i < 5; i++) begin
      do_cmd(cmds[i], rep, strb);
      n_cmp++;
      if (rep !== exps[i]) begin
        n_err++;
        $display("FAIL bad_arg cmd %h: got %h want %h", cmds[i], rep, exps[i]);
      end
    end
  endtask

  task automatic test_duty();
    logic [23:0] rep;
    logic [2:0]  strb;
    wait_sync();
    do_cmd(24'h300000, rep, strb);
    n_cmp++;
    if (rep !== 24'h340000) begin
      n_err++;
      $display("FAIL duty0_reply: got %h want 340000", rep);
    end
    do_cmd(24'h500000, rep, strb);
    n_cmp++;
    if (rep !== 24'h540408) begin
      n_err++;
      $display("FAIL duty_pending_status: got %h want 540408", rep);
    end
    wait_sync();
    wait_latches(PER - 1);
    for (int s = 0; s < PER; s++) begin
      n_cmp++;
      if (pat[s] !== 8'h00) begin
        n_err++;
        $display("FAIL duty0_pattern step %0d: got %h want 00", s, pat[s]);
      end
    end
    wait_sync();
    do_cmd(24'h300008, rep, strb);
    n_cmp++;
    if (rep !== 24'h340000) begin
      n_err++;
      $display("FAIL duty8_reply: got %h want 340000", rep);
    end
    wait_sync();
    wait_latches(PER - 1);
    for (int s = 0; s < PER; s++) begin
      n_cmp++;
      if (pat[s] !== 8'h20) begin
        n_err++;
        $display("FAIL duty8_pattern step %0d: got %h want 20", s, pat[s]);
      end
    end
    do_cmd(24'h300009, rep, strb);
    n_cmp++;
    if (rep !== 24'h310000) begin
      n_err++;
      $display("FAIL duty9_reply: got %h want 310000", rep);
    end
  endtask

  task automatic test_overflow();
    logic [23:0] rep;
    logic [2:0]  strb;
    i_overflow = 1'b1;
    tick();
    i_overflow = 1'b0;
    tick();
    do_cmd(24'h400500, rep, strb);
    n_cmp++;
    if (rep !== 24'h480083) begin
      n_err++;
      $display("FAIL ovf_read_reply: got %h want 480083", rep);
    end
    do_cmd(24'h500000, rep, strb);
    n_cmp++;
    if (rep !== 24'h580408) begin
      n_err++;
      $display("FAIL ovf_status_reply: got %h want 580408", rep);
    end
    do_cmd(24'h500000, rep, strb);
    n_cmp++;
    if (rep !== 24'h500408) begin
      n_err++;
      $display("FAIL ovf_cleared_reply: got %h want 500408", rep);
    end
  endtask

  task automatic test_reset_midshift();
    logic [23:0] rep;
    logic [2:0]  strb;
    int rises = 0;
    logic prev = 1'b0;
    int l0;
    bit found = 0;
    wait_sync();
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (o_data_clk && !prev) rises++;
      prev = o_data_clk;
      if (rises == 2 && !o_data_clk) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL reach_slot2: got %0d shift clocks want 2", rises);
    end
    l0 = lat_cnt;
    i_reset = 1'b1;
    tick();
    n_cmp++;
    if ({o_channel, o_data_clk, o_latch, o_sync, o_reply} !== '0) begin
      n_err++;
      $display("FAIL midshift_reset_outputs: got ch=%b dclk=%b lat=%b sync=%b rep=%b want 0",
               o_channel, o_data_clk, o_latch, o_sync, o_reply);
    end
    i_reset = 1'b0;
    for (int i = 0; i < 40 && lat_cnt == l0; i++) tick();
    n_cmp++;
    if (lat_cnt != l0 + 1 || last_sync !== 1'b1) begin
      n_err++;
      $display("FAIL restart_sync: got latches=%0d sync=%b want 1/1", lat_cnt - l0, last_sync);
    end
    n_cmp++;
    if (lat_vec !== 8'h00) begin
      n_err++;
      $display("FAIL restart_pattern: got %h want 00", lat_vec);
    end
    do_cmd(24'h400500, rep, strb);
    n_cmp++;
    if (rep !== 24'h400000) begin
      n_err++;
      $display("FAIL bank_cleared_read: got %h want 400000", rep);
    end
  endtask

  initial begin
    for (int l = 0; l < NL; l++) sr[l] = '0;
    for (int s = 0; s < PER; s++) pat[s] = '0;
    test_reset();
    test_write_swap();
    test_bad_args();
    test_duty();
    test_overflow();
    test_reset_midshift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
